// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Receive-side character FIFO for a UART. Stores each received
//             character with its parity/framing/break flags, reports
//             occupancy, raises a watermark interrupt and a character-timeout
//             interrupt, and keeps a sticky overflow flag for dropped chars.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,

  // Receive engine side
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_perr,
  input  logic          in_ferr,
  input  logic          in_berr,

  // Consumer side
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_perr,
  output logic          out_ferr,
  output logic          out_berr,
  output logic [CW-1:0] count,

  // Control / status
  input  logic          io_clear,
  input  logic [CW-1:0] io_wm,
  output logic          wm_irq,
  input  logic [15:0]   io_timeout,
  output logic          timeout_irq,
  output logic          overflow,
  input  logic          ovf_clr
);

  // Pointer width; DEPTH is a power of two so pointers wrap naturally.
  localparam int            AW       = $clog2(DEPTH);
  localparam int            EW       = 11;
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  // Entry layout: {berr, ferr, perr, data[7:0]}
  logic [EW-1:0]   mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [15:0]     idle_q,   idle_d;
  logic            overflow_q, overflow_d;

  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [EW-1:0]   w_head;

  // Handshake decode. A pop needs a non-empty FIFO; a push is allowed when
  // there is room or when a pop in the same cycle frees the slot. A flush
  // suppresses both, so nothing is written and nothing counts as dropped.
  always_comb begin
    w_empty = (count_q == '0);
    w_pop   = !io_clear && !w_empty && out_ready;
    w_push  = !io_clear && in_valid && ((count_q < DEPTH_CW) || w_pop);
    w_drop  = !io_clear && in_valid && !w_push;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (io_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Idle counter: restarts on any FIFO activity or while empty, otherwise
  // counts up to the programmed timeout and holds there. If the timeout is
  // lowered below the current count, it snaps to the new value.
  always_comb begin
    idle_d = idle_q;
    if (io_clear || w_push || w_pop || w_empty) begin
      idle_d = '0;
    end else if (io_timeout != '0) begin
      if (idle_q >= io_timeout) begin
        idle_d = io_timeout;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  // Sticky overflow: a drop in this cycle outranks a clear request.
  always_comb begin
    overflow_d = overflow_q;
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idle_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idle_q     <= idle_d;
      overflow_q <= overflow_d;
    end
  end

  // Character storage; contents are not reset, reads are masked when empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {in_berr, in_ferr, in_perr, in_data};
    end
  end

  // Head entry and status outputs. Masking with out_valid keeps the data
  // outputs at zero (never X) while the FIFO is empty.
  always_comb begin
    w_head      = mem_q[rd_ptr_q];
    out_valid   = !w_empty;
    out_data    = out_valid ? w_head[7:0] : 8'h00;
    out_perr    = out_valid ? w_head[8]   : 1'b0;
    out_ferr    = out_valid ? w_head[9]   : 1'b0;
    out_berr    = out_valid ? w_head[10]  : 1'b0;
    count       = count_q;
    overflow    = overflow_q;
    wm_irq      = (io_wm != '0) && (count_q >= io_wm);
    timeout_irq = (io_timeout != '0) && (idle_q == io_timeout) && !w_empty;
  end

endmodule
`default_nettype wire
